// File: rtl/weight_load_ctrl_pkg.sv
// Shared definitions for the weight-load framing controller: state encoding,
// error codes, sync bytes and the default payload length.
`timescale 1ns/1ps
package weight_load_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_LEN_HI  = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_BAD_LEN    = 3'd1,
    ERR_BAD_CKSUM  = 3'd2,
    ERR_TIMEOUT    = 3'd3,
    ERR_LOADER_INC = 3'd4
  } err_code_t;

  localparam logic [7:0] SYNC0_BYTE       = 8'hAA;
  localparam logic [7:0] SYNC1_BYTE       = 8'h55;
  localparam int         EXPECTED_LEN_DEF = 12984;

endpackage

// File: rtl/weight_load_ctrl_idle_timer.sv
// Counts consecutive idle clk cycles while enabled; expired_o flags the cycle
// in which the TIMEOUT_CYCLES-th idle cycle completes.
`timescale 1ns/1ps
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // A clear in the terminal cycle suppresses expiry: activity wins the race.
  assign expired_o = enable_i && !clear_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (!enable_i || clear_i) count_d = '0;
    else if (count_q != LAST) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/weight_load_ctrl.sv
// Receives a framed weight image over a UART byte stream, forwards the payload
// to the weight loader, and gates inference on a verified, complete load.
`timescale 1ns/1ps
module weight_load_ctrl
  import weight_load_ctrl_pkg::*;
#(
  parameter int EXPECTED_LEN   = EXPECTED_LEN_DEF,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        loader_done,
  output logic [7:0]  fwd_data,
  output logic        fwd_valid,
  output logic        loader_rst,
  output logic        infer_en,
  output logic        load_ok,
  output logic        load_err,
  output logic [2:0]  err_code,
  output logic [15:0] byte_count
);

  localparam logic [15:0] LEN_MATCH = 16'(EXPECTED_LEN);

  state_t      state_q;
  err_code_t   err_q;
  logic [7:0]  fwd_data_q;
  logic        fwd_valid_q;
  logic        loader_rst_q;
  logic        infer_en_q;
  logic        load_ok_q;
  logic        load_err_q;
  logic [15:0] byte_cnt_q;
  logic [15:0] len_q;
  logic [7:0]  cksum_q;

  logic        timer_en;
  logic        timer_exp;
  logic [15:0] len_full;

  assign timer_en = (state_q == ST_SYNC)    || (state_q == ST_LEN_LO) ||
                    (state_q == ST_LEN_HI)  || (state_q == ST_PAYLOAD) ||
                    (state_q == ST_CHECK);
  assign len_full = {rx_data, len_q[7:0]};

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (rx_ready),
    .enable_i  (timer_en),
    .expired_o (timer_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      err_q        <= ERR_NONE;
      fwd_data_q   <= '0;
      fwd_valid_q  <= 1'b0;
      loader_rst_q <= 1'b1;
      infer_en_q   <= 1'b0;
      load_ok_q    <= 1'b0;
      load_err_q   <= 1'b0;
      byte_cnt_q   <= '0;
      len_q        <= '0;
      cksum_q      <= '0;
    end else begin
      fwd_valid_q <= 1'b0;
      if (timer_exp) begin
        state_q      <= ST_ERROR;
        err_q        <= ERR_TIMEOUT;
        load_err_q   <= 1'b1;
        loader_rst_q <= 1'b1;
      end else if (rx_ready) begin
        case (state_q)
          ST_IDLE: begin
            if (rx_data == SYNC0_BYTE) begin
              state_q    <= ST_SYNC;
              byte_cnt_q <= '0;
              cksum_q    <= '0;
            end
          end
          ST_SYNC: begin
            if (rx_data == SYNC1_BYTE)      state_q <= ST_LEN_LO;
            else if (rx_data != SYNC0_BYTE) state_q <= ST_IDLE;
          end
          ST_LEN_LO: begin
            len_q[7:0] <= rx_data;
            state_q    <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            len_q[15:8] <= rx_data;
            if (len_full == LEN_MATCH) begin
              state_q      <= ST_PAYLOAD;
              loader_rst_q <= 1'b0;
              byte_cnt_q   <= '0;
              cksum_q      <= '0;
            end else begin
              state_q    <= ST_ERROR;
              err_q      <= ERR_BAD_LEN;
              load_err_q <= 1'b1;
            end
          end
          ST_PAYLOAD: begin
            fwd_data_q  <= rx_data;
            fwd_valid_q <= 1'b1;
            cksum_q     <= cksum_q + rx_data;
            byte_cnt_q  <= byte_cnt_q + 16'd1;
            if (byte_cnt_q == LEN_MATCH - 16'd1) state_q <= ST_CHECK;
          end
          ST_CHECK: begin
            if (rx_data != cksum_q) begin
              state_q      <= ST_ERROR;
              err_q        <= ERR_BAD_CKSUM;
              load_err_q   <= 1'b1;
              loader_rst_q <= 1'b1;
            end else if (!loader_done) begin
              state_q      <= ST_ERROR;
              err_q        <= ERR_LOADER_INC;
              load_err_q   <= 1'b1;
              loader_rst_q <= 1'b1;
            end else begin
              state_q    <= ST_DONE;
              load_ok_q  <= 1'b1;
              infer_en_q <= 1'b1;
            end
          end
          ST_DONE, ST_ERROR: begin
            // A new header from a terminal state discards the resident result.
            if (rx_data == SYNC0_BYTE) begin
              state_q      <= ST_SYNC;
              err_q        <= ERR_NONE;
              load_ok_q    <= 1'b0;
              load_err_q   <= 1'b0;
              infer_en_q   <= 1'b0;
              loader_rst_q <= 1'b1;
              byte_cnt_q   <= '0;
              cksum_q      <= '0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign fwd_data   = fwd_data_q;
  assign fwd_valid  = fwd_valid_q;
  assign loader_rst = loader_rst_q;
  assign infer_en   = infer_en_q;
  assign load_ok    = load_ok_q;
  assign load_err   = load_err_q;
  assign err_code   = err_q;
  assign byte_count = byte_cnt_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Directed bench for weight_load_ctrl with a small loader model that raises
// loader_done after eight forwarded strobes.
`timescale 1ns/1ps
module tb_weight_load_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        loader_done;
  logic [7:0]  fwd_data;
  logic        fwd_valid;
  logic        loader_rst;
  logic        infer_en;
  logic        load_ok;
  logic        load_err;
  logic [2:0]  err_code;
  logic [15:0] byte_count;

  int n_cmp  = 0;
  int n_fail = 0;

  int         fwd_total = 0;
  int         lrst_viol = 0;
  logic [7:0] fwd_log [0:255];
  int         ld_cnt = 0;

  weight_load_ctrl #(
    .EXPECTED_LEN   (8),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .loader_done (loader_done),
    .fwd_data    (fwd_data),
    .fwd_valid   (fwd_valid),
    .loader_rst  (loader_rst),
    .infer_en    (infer_en),
    .load_ok     (load_ok),
    .load_err    (load_err),
    .err_code    (err_code),
    .byte_count  (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (loader_rst)                 ld_cnt <= 0;
    else if (fwd_valid && ld_cnt < 8) ld_cnt <= ld_cnt + 1;
  end
  assign loader_done = (ld_cnt >= 8);

  always @(negedge clk) begin
    if (fwd_valid) begin
      fwd_log[fwd_total[7:0]] <= fwd_data;
      fwd_total <= fwd_total + 1;
      if (loader_rst) lrst_viol <= lrst_viol + 1;
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_payload_ck(input logic [7:0] ck);
    for (int i = 1; i <= 8; i++) send(8'(i));
    idle(2);
    send(ck);
    idle(1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_data = 8'h00; rx_ready = 1'b0;
    idle(3);
    n_cmp++; if (loader_rst !== 1'b1) begin n_fail++; $display("FAIL rst_loader_rst: got %b want 1", loader_rst); end
    n_cmp++; if (fwd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fwd_valid: got %b want 0", fwd_valid); end
    n_cmp++; if (fwd_data !== 8'h00) begin n_fail++; $display("FAIL rst_fwd_data: got %h want 00", fwd_data); end
    n_cmp++; if ({infer_en, load_ok, load_err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {infer_en, load_ok, load_err}); end
    n_cmp++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL rst_err_code: got %0d want 0", err_code); end
    n_cmp++; if (byte_count !== 16'd0) begin n_fail++; $display("FAIL rst_byte_count: got %0d want 0", byte_count); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame;
    int base, viol;
    base = fwd_total; viol = lrst_viol;
    send(8'hAA); send(8'h55); send(8'h08); send(8'h00);
    n_cmp++; if (loader_rst !== 1'b0) begin n_fail++; $display("FAIL good_lrst_payload: got %b want 0", loader_rst); end
    send_payload_ck(8'h24);
    n_cmp++; if (fwd_total - base !== 8) begin n_fail++; $display("FAIL good_fwd_count: got %0d want 8", fwd_total - base); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (fwd_log[(base + i) & 255] !== 8'(i + 1)) begin
        n_fail++; $display("FAIL good_fwd_data%0d: got %h want %h", i, fwd_log[(base + i) & 255], 8'(i + 1));
      end
    end
    n_cmp++; if (lrst_viol != viol) begin n_fail++; $display("FAIL good_lrst_at_fwd: got %0d want 0", lrst_viol - viol); end
    n_cmp++; if (byte_count !== 16'd8) begin n_fail++; $display("FAIL good_byte_count: got %0d want 8", byte_count); end
    n_cmp++; if ({load_ok, infer_en, load_err} !== 3'b110) begin n_fail++; $display("FAIL good_flags: got %b want 110", {load_ok, infer_en, load_err}); end
    n_cmp++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL good_err_code: got %0d want 0", err_code); end
  endtask

  task automatic test_bad_checksum;
    send(8'hAA);
    n_cmp++; if ({load_ok, infer_en} !== 2'b00) begin n_fail++; $display("FAIL resync_flags: got %b want 00", {load_ok, infer_en}); end
    send(8'h55); send(8'h08); send(8'h00);
    send_payload_ck(8'h25);
    n_cmp++; if ({load_err, load_ok, infer_en} !== 3'b100) begin n_fail++; $display("FAIL cksum_flags: got %b want 100", {load_err, load_ok, infer_en}); end
    n_cmp++; if (err_code !== 3'd2) begin n_fail++; $display("FAIL cksum_err_code: got %0d want 2", err_code); end
    n_cmp++; if (loader_rst !== 1'b1) begin n_fail++; $display("FAIL cksum_loader_rst: got %b want 1", loader_rst); end
  endtask

  task automatic test_bad_length;
    int base;
    base = fwd_total;
    send(8'hAA); send(8'h55); send(8'h09); send(8'h00);
    idle(3);
    n_cmp++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL len_load_err: got %b want 1", load_err); end
    n_cmp++; if (err_code !== 3'd1) begin n_fail++; $display("FAIL len_err_code: got %0d want 1", err_code); end
    n_cmp++; if (fwd_total - base !== 0) begin n_fail++; $display("FAIL len_fwd_count: got %0d want 0", fwd_total - base); end
  endtask

  task automatic test_timeout;
    send(8'hAA); send(8'h55); send(8'h08); send(8'h00); send(8'h01); send(8'h02);
    idle(999);
    n_cmp++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", load_err); end
    idle(1);
    n_cmp++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL tmo_load_err: got %b want 1", load_err); end
    n_cmp++; if (err_code !== 3'd3) begin n_fail++; $display("FAIL tmo_err_code: got %0d want 3", err_code); end
    n_cmp++; if (loader_rst !== 1'b1) begin n_fail++; $display("FAIL tmo_loader_rst: got %b want 1", loader_rst); end
    // Same stream, but a byte arrives in idle cycle 999.
    send(8'hAA); send(8'h55); send(8'h08); send(8'h00); send(8'h01); send(8'h02);
    idle(998);
    send(8'h03);
    idle(3);
    n_cmp++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL notmo_load_err: got %b want 0", load_err); end
    for (int i = 4; i <= 8; i++) send(8'(i));
    idle(2);
    send(8'h24);
    idle(1);
    n_cmp++; if ({load_ok, err_code} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL notmo_accept: got ok=%b code=%0d want ok=1 code=0", load_ok, err_code); end
  endtask

  task automatic test_sync_stay;
    int base;
    base = fwd_total;
    send(8'hAA); send(8'hAA); send(8'h55); send(8'h08); send(8'h00);
    send_payload_ck(8'h24);
    n_cmp++; if ({load_ok, infer_en, err_code} !== {2'b11, 3'd0}) begin n_fail++; $display("FAIL sync_accept: got %b want 11000", {load_ok, infer_en, err_code}); end
    n_cmp++; if (fwd_total - base !== 8) begin n_fail++; $display("FAIL sync_fwd_count: got %0d want 8", fwd_total - base); end
  endtask

  task automatic test_reset_mid;
    int base;
    send(8'hAA); send(8'h55); send(8'h08); send(8'h00);
    for (int i = 1; i <= 4; i++) send(8'(i));
    rst_n = 1'b0;
    #2;
    n_cmp++; if ({fwd_valid, fwd_data} !== 9'd0) begin n_fail++; $display("FAIL mid_fwd: got %b/%h want 0/00", fwd_valid, fwd_data); end
    n_cmp++; if ({loader_rst, infer_en, load_ok, load_err} !== 4'b1000) begin n_fail++; $display("FAIL mid_flags: got %b want 1000", {loader_rst, infer_en, load_ok, load_err}); end
    n_cmp++; if ({err_code, byte_count} !== 19'd0) begin n_fail++; $display("FAIL mid_counts: got code=%0d cnt=%0d want 0/0", err_code, byte_count); end
    idle(1);
    rst_n = 1'b1;
    idle(2);
    base = fwd_total;
    send(8'h05); send(8'h06);
    idle(2);
    n_cmp++; if (fwd_total - base !== 0) begin n_fail++; $display("FAIL mid_no_resume: got %0d want 0", fwd_total - base); end
    send(8'hAA); send(8'h55); send(8'h08); send(8'h00);
    send_payload_ck(8'h24);
    n_cmp++; if ({load_ok, infer_en, byte_count} !== {2'b11, 16'd8}) begin n_fail++; $display("FAIL mid_reload: got ok=%b en=%b cnt=%0d want 1 1 8", load_ok, infer_en, byte_count); end
    n_cmp++; if (fwd_total - base !== 8) begin n_fail++; $display("FAIL mid_fwd_count: got %0d want 8", fwd_total - base); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_timeout();
    test_sync_stay();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
